// File: rtl/score_disp_pkg.sv
// Shared constants, digit-index type and helpers for the score display scanner.
package score_disp_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned SEG_W      = 7;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned SCORE_W    = NUM_DIGITS * NIB_W;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
   localparam logic [SEG_W-1:0] SEG_OFF  = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;
   localparam logic [SEG_W-1:0] SEG_0    = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1    = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2    = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3    = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4    = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5    = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6    = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7    = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8    = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9    = 7'b0010000;

   // Digit index doubles as the scan state; order is ones -> thousands.
   typedef enum logic [1:0] {
      SLOT_ONES      = 2'd0,
      SLOT_TENS      = 2'd1,
      SLOT_HUNDREDS  = 2'd2,
      SLOT_THOUSANDS = 2'd3
   } digit_idx_t;

   function automatic logic [NUM_DIGITS-1:0] anode_low(input digit_idx_t idx);
      return ~(NUM_DIGITS'(1) << idx);
   endfunction

   function automatic logic [NIB_W-1:0] nibble_of(input logic [SCORE_W-1:0] v,
                                                  input digit_idx_t idx);
      logic [NIB_W-1:0] n;
      case (idx)
         SLOT_ONES:      n = v[3:0];
         SLOT_TENS:      n = v[7:4];
         SLOT_HUNDREDS:  n = v[11:8];
         default:        n = v[15:12];
      endcase
      return n;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment decoder; A-F show a dash.
module bcd_to_seg7
   import score_disp_pkg::*;
(
   input  logic [NIB_W-1:0] nibble,
   output logic [SEG_W-1:0] seg_c
);

   always_comb begin
      seg_c = SEG_DASH;
      case (nibble)
         4'd0:    seg_c = SEG_0;
         4'd1:    seg_c = SEG_1;
         4'd2:    seg_c = SEG_2;
         4'd3:    seg_c = SEG_3;
         4'd4:    seg_c = SEG_4;
         4'd5:    seg_c = SEG_5;
         4'd6:    seg_c = SEG_6;
         4'd7:    seg_c = SEG_7;
         4'd8:    seg_c = SEG_8;
         4'd9:    seg_c = SEG_9;
         default: seg_c = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/score_display_scanner.sv
// Time-multiplexed 4-digit common-anode display driver with per-frame score snapshot.
// Optional leading-zero blanking is compiled in when SCORE_DISP_LZB_EN is defined.
module score_display_scanner
   import score_disp_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [SCORE_W-1:0] score,
   output logic [NUM_DIGITS-1:0] an,
   output logic [SEG_W-1:0]   seg,
   output logic               dp,
   output logic               frame_start
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0]      cnt;
   digit_idx_t            idx;
   logic [SCORE_W-1:0]    snap;

   logic                  tick_c;
   logic                  wrap_c;
   digit_idx_t            idx_nx_c;
   logic [SCORE_W-1:0]    snap_nx_c;
   logic [NIB_W-1:0]      nib_c;
   logic [SEG_W-1:0]      dec_c;
   logic [NUM_DIGITS-1:0] blank_c;
   logic [NUM_DIGITS-1:0] an_nx_c;
   logic [SEG_W-1:0]      seg_nx_c;

   // Outputs are computed from the post-edge index and snapshot so they move with idx.
   always_comb begin
      tick_c    = (cnt == CNT_MAX);
      wrap_c    = tick_c && (idx == SLOT_THOUSANDS);
      idx_nx_c  = tick_c ? digit_idx_t'(idx + 2'd1) : idx;
      snap_nx_c = wrap_c ? score : snap;
      nib_c     = nibble_of(snap_nx_c, idx_nx_c);
   end

   bcd_to_seg7 u_dec (
      .nibble (nib_c),
      .seg_c  (dec_c)
   );

`ifdef SCORE_DISP_LZB_EN
   // A digit blanks only when it and every higher digit are zero; ones never blanks.
   always_comb begin
      blank_c    = '0;
      blank_c[3] = (snap_nx_c[15:12] == 4'd0);
      blank_c[2] = blank_c[3] && (snap_nx_c[11:8] == 4'd0);
      blank_c[1] = blank_c[2] && (snap_nx_c[7:4] == 4'd0);
      blank_c[0] = 1'b0;
   end
`else
   assign blank_c = '0;
`endif

   always_comb begin
      an_nx_c  = anode_low(idx_nx_c);
      seg_nx_c = dec_c;
      if (blank_c[idx_nx_c]) begin
         an_nx_c  = '1;
         seg_nx_c = SEG_OFF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         idx         <= SLOT_THOUSANDS;
         snap        <= '0;
         an          <= '1;
         seg         <= SEG_OFF;
         frame_start <= 1'b0;
      end else begin
         cnt         <= tick_c ? '0 : cnt + CNT_W'(1);
         idx         <= idx_nx_c;
         snap        <= snap_nx_c;
         frame_start <= wrap_c;
         if (tick_c) begin
            an  <= an_nx_c;
            seg <= seg_nx_c;
         end
      end
   end

   assign dp = 1'b1;

endmodule

// File: tb/tb_score_display_scanner.sv
// Directed self-checking bench for score_display_scanner with REFRESH_DIV = 4.
module tb_score_display_scanner;

   localparam int unsigned RD = 4;

   localparam logic [6:0] S_OFF  = 7'b1111111;
   localparam logic [6:0] S_DASH = 7'b0111111;
   localparam logic [6:0] S_0    = 7'b1000000;
   localparam logic [6:0] S_1    = 7'b1111001;
   localparam logic [6:0] S_2    = 7'b0100100;
   localparam logic [6:0] S_3    = 7'b0110000;
   localparam logic [6:0] S_4    = 7'b0011001;
   localparam logic [6:0] S_5    = 7'b0010010;
   localparam logic [6:0] S_9    = 7'b0010000;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] score;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_start;

   int n_cmp = 0;
   int n_err = 0;

   score_display_scanner #(.REFRESH_DIV(RD)) dut (
      .clk         (clk),
      .rst         (rst),
      .score       (score),
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Advance to the cycle just after the next frame_start pulse (bounded).
   task automatic wait_frame(input string tag);
      int k;
      k = 0;
      do begin
         step(1);
         k++;
      end while (frame_start !== 1'b1 && k < 40);
      n_cmp++;
      if (frame_start !== 1'b1) begin
         n_err++;
         $display("FAIL %s wait_frame: frame_start=%b after %0d cycles, required 1", tag, frame_start, k);
      end
   endtask

   task automatic test_reset;
      rst   = 1'b1;
      score = 16'h1234;
      step(2);
      n_cmp++;
      if (an !== 4'b1111 || seg !== S_OFF || dp !== 1'b1 || frame_start !== 1'b0) begin
         n_err++;
         $display("FAIL reset_vals: an=%b seg=%b dp=%b fs=%b, required 1111 1111111 1 0", an, seg, dp, frame_start);
      end
      rst = 1'b0;
      step(3);
      n_cmp++;
      if (an !== 4'b1111 || frame_start !== 1'b0) begin
         n_err++;
         $display("FAIL reset_pre_tick: an=%b fs=%b, required 1111 0", an, frame_start);
      end
      step(1);
      n_cmp++;
      if (an !== 4'b1110 || seg !== S_4 || frame_start !== 1'b1) begin
         n_err++;
         $display("FAIL reset_first_tick: an=%b seg=%b fs=%b, required 1110 %b 1", an, seg, frame_start, S_4);
      end
      step(1);
      n_cmp++;
      if (frame_start !== 1'b0 || an !== 4'b1110) begin
         n_err++;
         $display("FAIL reset_pulse_width: an=%b fs=%b, required 1110 0", an, frame_start);
      end
   endtask

   task automatic test_full_scan;
      logic [6:0] exp_seg [4];
      logic [3:0] exp_an  [4];
      logic       exp_fs;
      exp_seg = '{S_4, S_3, S_2, S_1};
      exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      wait_frame("full_scan");
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < int'(RD); c++) begin
            exp_fs = (s == 0 && c == 0);
            n_cmp++;
            if (an !== exp_an[s] || seg !== exp_seg[s] || frame_start !== exp_fs || dp !== 1'b1) begin
               n_err++;
               $display("FAIL full_scan s%0d c%0d: an=%b seg=%b fs=%b dp=%b, required %b %b %b 1",
                        s, c, an, seg, frame_start, dp, exp_an[s], exp_seg[s], exp_fs);
            end
            step(1);
         end
      end
      n_cmp++;
      if (frame_start !== 1'b1 || an !== 4'b1110) begin
         n_err++;
         $display("FAIL frame_period: fs=%b an=%b 16 cycles later, required 1 1110", frame_start, an);
      end
   endtask

   task automatic test_tearing;
      score = 16'h0009;
      wait_frame("tearing_a");
      n_cmp++;
      if (an !== 4'b1110 || seg !== S_9) begin
         n_err++;
         $display("FAIL tear_slot0: an=%b seg=%b, required 1110 %b", an, seg, S_9);
      end
      step(4);
      step(1);
      score = 16'h0010;
      step(2);
      n_cmp++;
`ifdef SCORE_DISP_LZB_EN
      if (an !== 4'b1111 || seg !== S_OFF) begin
         n_err++;
         $display("FAIL tear_slot1_hold: an=%b seg=%b, required 1111 %b", an, seg, S_OFF);
      end
`else
      if (an !== 4'b1101 || seg !== S_0) begin
         n_err++;
         $display("FAIL tear_slot1_hold: an=%b seg=%b, required 1101 %b", an, seg, S_0);
      end
`endif
      wait_frame("tearing_b");
      n_cmp++;
      if (an !== 4'b1110 || seg !== S_0) begin
         n_err++;
         $display("FAIL tear_next_slot0: an=%b seg=%b, required 1110 %b", an, seg, S_0);
      end
      step(4);
      n_cmp++;
      if (an !== 4'b1101 || seg !== S_1) begin
         n_err++;
         $display("FAIL tear_next_slot1: an=%b seg=%b, required 1101 %b", an, seg, S_1);
      end
   endtask

   task automatic test_lzb;
      logic [3:0] e_an2, e_an3;
      logic [6:0] e_hi;
`ifdef SCORE_DISP_LZB_EN
      e_an2 = 4'b1111; e_an3 = 4'b1111; e_hi = S_OFF;
`else
      e_an2 = 4'b1011; e_an3 = 4'b0111; e_hi = S_0;
`endif
      score = 16'h0050;
      wait_frame("lzb");
      n_cmp++;
      if (an !== 4'b1110 || seg !== S_0) begin
         n_err++;
         $display("FAIL lzb_slot0: an=%b seg=%b, required 1110 %b", an, seg, S_0);
      end
      step(4);
      n_cmp++;
      if (an !== 4'b1101 || seg !== S_5) begin
         n_err++;
         $display("FAIL lzb_slot1: an=%b seg=%b, required 1101 %b", an, seg, S_5);
      end
      step(4);
      n_cmp++;
      if (an !== e_an2 || seg !== e_hi) begin
         n_err++;
         $display("FAIL lzb_slot2: an=%b seg=%b, required %b %b", an, seg, e_an2, e_hi);
      end
      step(4);
      n_cmp++;
      if (an !== e_an3 || seg !== e_hi) begin
         n_err++;
         $display("FAIL lzb_slot3: an=%b seg=%b, required %b %b", an, seg, e_an3, e_hi);
      end
   endtask

   task automatic test_nonbcd_max;
      logic [3:0] exp_an [4];
      exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      score = 16'h00A0;
      wait_frame("nonbcd");
      step(4);
      n_cmp++;
      if (an !== 4'b1101 || seg !== S_DASH) begin
         n_err++;
         $display("FAIL nonbcd_slot1: an=%b seg=%b, required 1101 %b", an, seg, S_DASH);
      end
      score = 16'h9999;
      wait_frame("max");
      for (int s = 0; s < 4; s++) begin
         n_cmp++;
         if (an !== exp_an[s] || seg !== S_9) begin
            n_err++;
            $display("FAIL max_slot%0d: an=%b seg=%b, required %b %b", s, an, seg, exp_an[s], S_9);
         end
         step(4);
      end
   endtask

   task automatic test_mid_reset;
      wait_frame("mid_reset");
      step(8);
      step(1);
      n_cmp++;
      if (an !== 4'b1011 || seg !== S_9) begin
         n_err++;
         $display("FAIL midrst_pre: an=%b seg=%b, required 1011 %b", an, seg, S_9);
      end
      rst = 1'b1;
      step(1);
      n_cmp++;
      if (an !== 4'b1111 || seg !== S_OFF || frame_start !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_vals: an=%b seg=%b fs=%b, required 1111 %b 0", an, seg, frame_start, S_OFF);
      end
      rst = 1'b0;
      step(3);
      n_cmp++;
      if (an !== 4'b1111) begin
         n_err++;
         $display("FAIL midrst_pre_tick: an=%b, required 1111", an);
      end
      step(1);
      n_cmp++;
      if (an !== 4'b1110 || seg !== S_9 || frame_start !== 1'b1) begin
         n_err++;
         $display("FAIL midrst_resume: an=%b seg=%b fs=%b, required 1110 %b 1", an, seg, frame_start, S_9);
      end
   endtask

   initial begin
      rst   = 1'b1;
      score = 16'h0000;
      test_reset();
      test_full_scan();
      test_tearing();
      test_lzb();
      test_nonbcd_max();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
